// File: rtl/writeback_pipe_pkg.sv
// Shared definitions for the writeback stage: opcodes, load size codes,
// occupancy states and the register-write qualification helper.
package writeback_pipe_pkg;

    // Default datapath width used by the writeback stage
    localparam int N = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_t;

    // Branches and stores retire without a register write; x0 is never written
    function automatic logic wr_type(input logic [6:0] opcode, input logic [4:0] rd);
        return !(opcode == OPC_BRANCH || opcode == OPC_STORE) && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/writeback_pipe_load_align.sv
// Combinational load formatter: extracts the addressed byte/half/word from
// the aligned memory word and sign- or zero-extends it to XLEN.
module load_align
    import writeback_pipe_pkg::*;
#(
    parameter int XLEN = N,
    localparam int OFS_W = $clog2(XLEN / 8)
) (
    input  logic [2:0]       funct3,
    input  logic [OFS_W-1:0] addr_lo,
    input  logic [XLEN-1:0]  load_data,
    output logic [XLEN-1:0]  data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] word_v;

    // Misaligned offsets simply drop the low bits below the access size
    assign byte_v = 8'(load_data >> {addr_lo, 3'b000});
    assign half_v = 16'(load_data >> {addr_lo[OFS_W-1:1], 4'b0000});
    assign word_v = (XLEN == 64) ? 32'(load_data >> {addr_lo[OFS_W-1], 5'b00000})
                                 : 32'(load_data);

    // Select and extend according to the load size code
    always_comb begin
        data = load_data;
        case (funct3)
            F3_LB:  data = XLEN'($signed(byte_v));
            F3_LBU: data = XLEN'(byte_v);
            F3_LH:  data = XLEN'($signed(half_v));
            F3_LHU: data = XLEN'(half_v);
            F3_LW:  data = XLEN'($signed(word_v));
            F3_LWU: if (XLEN == 64) data = XLEN'(word_v);
            F3_LD:  data = load_data;
            default: data = load_data;
        endcase
    end

endmodule

// File: rtl/writeback_pipe.sv
// Writeback stage: two-entry output/skid pipeline feeding the register file,
// with a forwarding copy of the held result and a retired-instruction counter.
module writeback_pipe
    import writeback_pipe_pkg::*;
#(
    parameter int XLEN  = N,
    parameter int CNT_W = 64,
    localparam int OFS_W = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_vld,
    output logic              o_mem_rdy,
    input  logic [4:0]        i_rd,
    input  logic [6:0]        i_opcode,
    input  logic [2:0]        i_funct3,
    input  logic [OFS_W-1:0]  i_addr_lo,
    input  logic [XLEN-1:0]   i_alu_data,
    input  logic [XLEN-1:0]   i_load_data,
    input  logic              i_stall,
    output logic              o_rf_wr,
    output logic [4:0]        o_rf_rd,
    output logic [XLEN-1:0]   o_rf_data,
    output logic              o_fwd_vld,
    output logic [4:0]        o_fwd_rd,
    output logic [XLEN-1:0]   o_fwd_data,
    output logic [CNT_W-1:0]  o_instret
);

    occ_t              state, state_next;
    logic              rdy_q;
    logic              accept, drain, out_vld;
    logic              new_wr;
    logic [XLEN-1:0]   new_data, load_fmt;
    logic              out_wr, skd_wr;
    logic [4:0]        out_rd, skd_rd;
    logic [XLEN-1:0]   out_data, skd_data;
    logic [CNT_W-1:0]  instret;

    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3    (i_funct3),
        .addr_lo   (i_addr_lo),
        .load_data (i_load_data),
        .data      (load_fmt)
    );

    assign out_vld  = (state != OCC_EMPTY);
    assign accept   = i_mem_vld & rdy_q;
    assign drain    = out_vld & ~i_stall;
    assign new_wr   = wr_type(i_opcode, i_rd);
    assign new_data = (i_opcode == OPC_LOAD) ? load_fmt : i_alu_data;

    // Occupancy transitions; accept-with-drain keeps the count unchanged
    always_comb begin
        state_next = state;
        case (state)
            OCC_EMPTY: if (accept) state_next = OCC_ONE;
            OCC_ONE: begin
                if (accept && i_stall)       state_next = OCC_FULL;
                else if (!accept && !i_stall) state_next = OCC_EMPTY;
            end
            OCC_FULL:  if (!i_stall) state_next = OCC_ONE;
            default:   state_next = OCC_EMPTY;
        endcase
    end

    // Occupancy, registered ready and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= OCC_EMPTY;
            rdy_q   <= 1'b0;
            instret <= '0;
        end else begin
            state <= state_next;
            rdy_q <= (state_next != OCC_FULL);
            if (drain) instret <= instret + CNT_W'(1);
        end
    end

    // Entry storage: new data lands in OUT when it is free or draining, else in SKD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_wr   <= 1'b0;
            out_rd   <= '0;
            out_data <= '0;
            skd_wr   <= 1'b0;
            skd_rd   <= '0;
            skd_data <= '0;
        end else begin
            if (accept && (state == OCC_EMPTY || drain)) begin
                out_wr   <= new_wr;
                out_rd   <= i_rd;
                out_data <= new_data;
            end else if (state == OCC_FULL && drain) begin
                out_wr   <= skd_wr;
                out_rd   <= skd_rd;
                out_data <= skd_data;
            end
            if (accept && state == OCC_ONE && !drain) begin
                skd_wr   <= new_wr;
                skd_rd   <= i_rd;
                skd_data <= new_data;
            end
        end
    end

    assign o_mem_rdy  = rdy_q;
    assign o_rf_wr    = out_vld & out_wr & ~i_stall;
    assign o_rf_rd    = out_vld ? out_rd : 5'd0;
    assign o_rf_data  = out_vld ? out_data : '0;
    assign o_fwd_vld  = out_vld & out_wr;
    assign o_fwd_rd   = o_rf_rd;
    assign o_fwd_data = o_rf_data;
    assign o_instret  = instret;

endmodule

// File: tb/tb_writeback_pipe.sv
// Directed self-checking bench for writeback_pipe with a queue scoreboard.
module tb_writeback_pipe;
    import writeback_pipe_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic              clk;
    logic              rst_n;
    logic              i_mem_vld;
    logic              o_mem_rdy;
    logic [4:0]        i_rd;
    logic [6:0]        i_opcode;
    logic [2:0]        i_funct3;
    logic [1:0]        i_addr_lo;
    logic [XLEN-1:0]   i_alu_data;
    logic [XLEN-1:0]   i_load_data;
    logic              i_stall;
    logic              o_rf_wr;
    logic [4:0]        o_rf_rd;
    logic [XLEN-1:0]   o_rf_data;
    logic              o_fwd_vld;
    logic [4:0]        o_fwd_rd;
    logic [XLEN-1:0]   o_fwd_data;
    logic [CNT_W-1:0]  o_instret;

    writeback_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mem_vld   (i_mem_vld),
        .o_mem_rdy   (o_mem_rdy),
        .i_rd        (i_rd),
        .i_opcode    (i_opcode),
        .i_funct3    (i_funct3),
        .i_addr_lo   (i_addr_lo),
        .i_alu_data  (i_alu_data),
        .i_load_data (i_load_data),
        .i_stall     (i_stall),
        .o_rf_wr     (o_rf_wr),
        .o_rf_rd     (o_rf_rd),
        .o_rf_data   (o_rf_data),
        .o_fwd_vld   (o_fwd_vld),
        .o_fwd_rd    (o_fwd_rd),
        .o_fwd_data  (o_fwd_data),
        .o_instret   (o_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t             q[$];
    logic             m_rdy;
    logic [CNT_W-1:0] m_instret;
    int               checks = 0;
    int               errors = 0;

    localparam logic [6:0] OPC_ALU = 7'b0110011;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check combinational write enable, clock, update model, check outputs
    task automatic cyc(input logic vld, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [1:0] ofs, input logic [31:0] alu,
                       input logic [31:0] ld, input logic stall, input logic ewr,
                       input logic [31:0] edata);
        logic acc, dr;
        ent_t e;
        i_mem_vld   = vld;
        i_opcode    = opc;
        i_funct3    = f3;
        i_rd        = rd;
        i_addr_lo   = ofs;
        i_alu_data  = alu;
        i_load_data = ld;
        i_stall     = stall;
        #1;
        chk("rf_wr", {63'd0, o_rf_wr}, {63'd0, (q.size() > 0) ? (q[0].wr & ~stall) : 1'b0});
        acc = vld & m_rdy;
        dr  = (q.size() > 0) && !stall;
        @(posedge clk);
        if (dr) begin
            void'(q.pop_front());
            m_instret = m_instret + 1'b1;
        end
        if (acc) begin
            e.wr = ewr; e.rd = rd; e.data = edata;
            q.push_back(e);
        end
        m_rdy = (q.size() < 2);
        #1;
        chk("mem_rdy", {63'd0, o_mem_rdy}, {63'd0, m_rdy});
        chk("fwd_vld", {63'd0, o_fwd_vld}, {63'd0, (q.size() > 0) ? q[0].wr : 1'b0});
        chk("rf_rd", {59'd0, o_rf_rd}, {59'd0, (q.size() > 0) ? q[0].rd : 5'd0});
        chk("rf_data", {32'd0, o_rf_data}, {32'd0, (q.size() > 0) ? q[0].data : 32'd0});
        chk("fwd_rd", {59'd0, o_fwd_rd}, {59'd0, (q.size() > 0) ? q[0].rd : 5'd0});
        chk("fwd_data", {32'd0, o_fwd_data}, {32'd0, (q.size() > 0) ? q[0].data : 32'd0});
        chk("instret", {60'd0, o_instret}, {60'd0, m_instret});
    endtask

    task automatic idle(input logic stall);
        cyc(1'b0, OPC_ALU, 3'd0, 5'd0, 2'd0, 32'd0, 32'd0, stall, 1'b0, 32'd0);
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] d, input logic stall);
        cyc(1'b1, OPC_ALU, 3'd0, rd, 2'd0, d, 32'hDEAD_BEEF, stall, (rd != 0), d);
    endtask

    task automatic load_op(input logic [2:0] f3, input logic [1:0] ofs, input logic [31:0] ld,
                           input logic [31:0] edata);
        cyc(1'b1, OPC_LOAD, f3, 5'd7, ofs, 32'h5555_5555, ld, 1'b0, 1'b1, edata);
    endtask

    initial begin
        rst_n = 1'b0; i_mem_vld = 1'b1; i_rd = 5'd3; i_opcode = OPC_ALU; i_funct3 = 3'd0;
        i_addr_lo = 2'd0; i_alu_data = 32'h1111; i_load_data = 32'd0; i_stall = 1'b0;
        m_rdy = 1'b0; m_instret = '0;

        // Reset held with a valid request present
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_wr", {63'd0, o_rf_wr}, 64'd0);
        chk("rst_instret", {60'd0, o_instret}, 64'd0);
        chk("rst_rdy", {63'd0, o_mem_rdy}, 64'd0);
        chk("rst_fwd_vld", {63'd0, o_fwd_vld}, 64'd0);
        rst_n = 1'b1;
        idle(1'b0);
        chk("rdy_after_rst", {63'd0, o_mem_rdy}, 64'd1);

        // Basic ALU result, then drain
        alu_op(5'd5, 32'h0000_1234, 1'b0);
        chk("alu_rd", {59'd0, o_rf_rd}, 64'd5);
        chk("alu_data", {32'd0, o_rf_data}, 64'h1234);
        idle(1'b0);
        chk("alu_instret", {60'd0, o_instret}, 64'd1);

        // Load formatting
        load_op(F3_LB,  2'd1, 32'h0000_8000, 32'hFFFF_FF80);
        load_op(F3_LHU, 2'd0, 32'h0000_8000, 32'h0000_8000);
        load_op(F3_LH,  2'd2, 32'h8000_0000, 32'hFFFF_8000);
        load_op(F3_LBU, 2'd3, 32'hAB00_0000, 32'h0000_00AB);
        load_op(F3_LB,  2'd0, 32'h0000_007F, 32'h0000_007F);
        load_op(F3_LW,  2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D);
        load_op(F3_LH,  2'd3, 32'h7654_3210, 32'h0000_7654);
        load_op(3'b011, 2'd2, 32'h1357_9BDF, 32'h1357_9BDF);
        load_op(3'b111, 2'd1, 32'h0246_8ACE, 32'h0246_8ACE);
        idle(1'b0);

        // Stall with back-to-back sends: OUT then SKD fill, third ignored
        alu_op(5'd10, 32'hA0A0_0001, 1'b1);
        alu_op(5'd11, 32'hA0A0_0002, 1'b1);
        chk("rdy_full", {63'd0, o_mem_rdy}, 64'd0);
        alu_op(5'd12, 32'hA0A0_0003, 1'b1);
        alu_op(5'd12, 32'hA0A0_0003, 1'b0);
        alu_op(5'd12, 32'hA0A0_0003, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("stall_drained", q.size(), 64'd0);

        // Store and rd=0 retire without writing
        cyc(1'b1, OPC_STORE, 3'd2, 5'd9, 2'd0, 32'h99, 32'd0, 1'b0, 1'b0, 32'h99);
        alu_op(5'd0, 32'h77, 1'b0);
        cyc(1'b1, OPC_BRANCH, 3'd0, 5'd4, 2'd0, 32'h44, 32'd0, 1'b0, 1'b0, 32'h44);
        idle(1'b0);
        idle(1'b0);

        // Reset while full: entries discarded, nothing written
        alu_op(5'd20, 32'hBBBB_0001, 1'b1);
        alu_op(5'd21, 32'hBBBB_0002, 1'b1);
        i_mem_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rf_wr", {63'd0, o_rf_wr}, 64'd0);
        chk("mid_rst_fwd_vld", {63'd0, o_fwd_vld}, 64'd0);
        chk("mid_rst_rdy", {63'd0, o_mem_rdy}, 64'd0);
        chk("mid_rst_instret", {60'd0, o_instret}, 64'd0);
        chk("mid_rst_rf_data", {32'd0, o_rf_data}, 64'd0);
        q.delete();
        m_rdy = 1'b0;
        m_instret = '0;
        i_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b0);

        // Counter wrap: 17 retires on a 4-bit counter
        for (int i = 0; i < 17; i++) alu_op(5'(i % 31 + 1), 32'h100 + i, 1'b0);
        idle(1'b0);
        chk("wrap_instret", {60'd0, o_instret}, 64'd1);
        chk("end_empty", q.size(), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
